// File: rtl/regfile_write_arbiter.sv
// Register-file write-port scheduler: two writeback requesters (A = ALU,
// B = load) each queue writes in a small FIFO; a round-robin arbiter drains
// them into a registered write strobe/address/data.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W-1:0]        b_addr,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     wr_src,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  logic [ADDR_W-1:0] a_mem_addr [DEPTH];
  logic [DATA_W-1:0] a_mem_data [DEPTH];
  logic [ADDR_W-1:0] b_mem_addr [DEPTH];
  logic [DATA_W-1:0] b_mem_data [DEPTH];

  logic [PTR_W-1:0]  a_wptr, a_rptr, b_wptr, b_rptr;
  logic              ready_en;
  src_e              rr;
  src_e              wr_src_q;

  logic              a_push, b_push;
  logic              a_nempty, b_nempty;
  logic              pop_a, pop_b;

  // Ready depends only on registered state: count and the post-reset enable.
  assign a_ready  = ready_en && (a_count < CNT_W'(DEPTH));
  assign b_ready  = ready_en && (b_count < CNT_W'(DEPTH));

  // Writes to $zero complete the handshake but are never queued.
  assign a_push   = a_valid && a_ready && (a_addr != '0);
  assign b_push   = b_valid && b_ready && (b_addr != '0);

  assign a_nempty = (a_count != '0);
  assign b_nempty = (b_count != '0);

  assign wr_src   = wr_src_q;

  // Round-robin pop selection from registered FIFO occupancy.
  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (a_nempty && (!b_nempty || rr == SRC_A)) begin
      pop_a = 1'b1;
    end else if (b_nempty) begin
      pop_b = 1'b1;
    end
  end

  // Ready is held low during reset and enabled on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // A FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (a_push) begin
      a_mem_addr[a_wptr] <= a_addr;
      a_mem_data[a_wptr] <= a_data;
    end
  end

  // B FIFO storage.
  always_ff @(posedge clk) begin
    if (b_push) begin
      b_mem_addr[b_wptr] <= b_addr;
      b_mem_data[b_wptr] <= b_data;
    end
  end

  // A FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_wptr  <= '0;
      a_rptr  <= '0;
      a_count <= '0;
    end else begin
      if (a_push) a_wptr <= a_wptr + PTR_W'(1);
      if (pop_a)  a_rptr <= a_rptr + PTR_W'(1);
      case ({a_push, pop_a})
        2'b10:   a_count <= a_count + CNT_W'(1);
        2'b01:   a_count <= a_count - CNT_W'(1);
        default: a_count <= a_count;
      endcase
    end
  end

  // B FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_wptr  <= '0;
      b_rptr  <= '0;
      b_count <= '0;
    end else begin
      if (b_push) b_wptr <= b_wptr + PTR_W'(1);
      if (pop_b)  b_rptr <= b_rptr + PTR_W'(1);
      case ({b_push, pop_b})
        2'b10:   b_count <= b_count + CNT_W'(1);
        2'b01:   b_count <= b_count - CNT_W'(1);
        default: b_count <= b_count;
      endcase
    end
  end

  // Round-robin pointer moves to the side not popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= SRC_A;
    end else if (pop_a) begin
      rr <= SRC_B;
    end else if (pop_b) begin
      rr <= SRC_A;
    end
  end

  // Registered write port: strobe for one cycle per pop, hold fields otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_src_q <= SRC_A;
    end else if (pop_a) begin
      wr_en    <= 1'b1;
      wr_addr  <= a_mem_addr[a_rptr];
      wr_data  <= a_mem_data[a_rptr];
      wr_src_q <= SRC_A;
    end else if (pop_b) begin
      wr_en    <= 1'b1;
      wr_addr  <= b_mem_addr[b_rptr];
      wr_data  <= b_mem_data[b_rptr];
      wr_src_q <= SRC_B;
    end else begin
      wr_en    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_src;
  logic [1:0]        a_count, b_count;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_addr (a_addr),
    .a_data (a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_addr (b_addr),
    .b_data (b_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_src (wr_src),
    .a_count(a_count),
    .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({wr_en, wr_src, a_ready, b_ready, a_count, b_count} !== 8'h00) begin
        errors++;
        $display("FAIL reset_ctrl: got en=%b src=%b ar=%b br=%b ac=%0d bc=%0d, want all 0",
                 wr_en, wr_src, a_ready, b_ready, a_count, b_count);
      end
      checks++;
      if ({wr_addr, wr_data} !== '0) begin
        errors++;
        $display("FAIL reset_data: got addr=%0d data=%h, want 0", wr_addr, wr_data);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_release: got ar=%b br=%b, want 1 1", a_ready, b_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_wr_en: got %b, want 0", wr_en);
      end
    end
  endtask

  task automatic test_single(input logic side, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
    @(negedge clk);
    if (side == 1'b0) begin
      a_valid = 1'b1; a_addr = addr; a_data = data;
    end else begin
      b_valid = 1'b1; b_addr = addr; b_data = data;
    end
    checks++;
    if ((side ? b_ready : a_ready) !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got 0, want 1 (side %0d)", side);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || (side ? b_count : a_count) !== 2'd1) begin
      errors++;
      $display("FAIL single_queued: got en=%b count=%0d, want en=0 count=1",
               wr_en, side ? b_count : a_count);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== addr || wr_data !== data || wr_src !== side) begin
      errors++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h src=%b, want 1 %0d %h %b",
               wr_en, wr_addr, wr_data, wr_src, addr, data, side);
    end
    checks++;
    if ((side ? b_count : a_count) !== 2'd0) begin
      errors++;
      $display("FAIL single_drained: got count=%0d, want 0", side ? b_count : a_count);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== addr) begin
      errors++;
      $display("FAIL single_hold: got en=%b addr=%0d, want en=0 addr=%0d", wr_en, wr_addr, addr);
    end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] exp_addr [4];
    logic [DATA_W-1:0] exp_data [4];
    logic              exp_src  [4];
    exp_addr = '{5'd1, 5'd3, 5'd2, 5'd4};
    exp_data = '{32'h0000_1111, 32'h0000_3333, 32'h0000_2222, 32'h0000_4444};
    exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_1111;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h0000_3333;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_first: got en=%b ar=%b br=%b, want 0 1 1", wr_en, a_ready, b_ready);
    end
    a_addr = 5'd2; a_data = 32'h0000_2222;
    b_addr = 5'd4; b_data = 32'h0000_4444;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== exp_addr[i] || wr_data !== exp_data[i] ||
          wr_src !== exp_src[i]) begin
        errors++;
        $display("FAIL contention_order[%0d]: got en=%b addr=%0d data=%h src=%b, want 1 %0d %h %b",
                 i, wr_en, wr_addr, wr_data, wr_src, exp_addr[i], exp_data[i], exp_src[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL contention_end: got en=%b, want 0", wr_en);
    end
  endtask

  task automatic test_backpressure();
    int  a_idx = 0, b_idx = 0, a_got = 0, b_got = 0;
    bit  a_pend = 0, b_pend = 0, saw_full = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (wr_src === 1'b1) begin
          checks++;
          if (b_got >= 8 || wr_addr !== 5'(8 + b_got) || wr_data !== 32'hB000_0000 + b_got) begin
            errors++;
            $display("FAIL bp_b_write[%0d]: got addr=%0d data=%h, want %0d %h",
                     b_got, wr_addr, wr_data, 8 + b_got, 32'hB000_0000 + b_got);
          end
          b_got++;
        end else begin
          checks++;
          if (a_got >= 8 || wr_addr !== 5'(16 + a_got) || wr_data !== 32'hA000_0000 + a_got) begin
            errors++;
            $display("FAIL bp_a_write[%0d]: got addr=%0d data=%h, want %0d %h",
                     a_got, wr_addr, wr_data, 16 + a_got, 32'hA000_0000 + a_got);
          end
          a_got++;
        end
      end
      if (b_count === 2'd2) saw_full = 1;
      checks++;
      if (b_ready !== (b_count != 2'd2) || b_count > 2'd2) begin
        errors++;
        $display("FAIL bp_b_ready: got ready=%b count=%0d, want ready=1 iff count<2",
                 b_ready, b_count);
      end
      if (a_pend) a_idx++;
      if (b_pend) b_idx++;
      a_valid = (a_idx < 8); a_addr = 5'(16 + a_idx); a_data = 32'hA000_0000 + a_idx;
      b_valid = (b_idx < 8); b_addr = 5'(8 + b_idx);  b_data = 32'hB000_0000 + b_idx;
      a_pend  = a_valid && a_ready;
      b_pend  = b_valid && b_ready;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++;
    if (b_got != 8 || a_got != 8) begin
      errors++;
      $display("FAIL bp_totals: got a=%0d b=%0d writes, want 8 8", a_got, b_got);
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL bp_b_full: got max b_count<2, want b_count to reach 2");
    end
  endtask

  task automatic test_zero();
    int writes = 0;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0000_1234;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_handshake: got ready=%b, want 1", a_ready);
    end
    @(negedge clk);
    checks++;
    if (a_count !== 2'd0 || wr_en !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_not_queued: got count=%0d en=%b ready=%b, want 0 0 1",
               a_count, wr_en, a_ready);
    end
    a_addr = 5'd7; a_data = 32'h0000_0055;
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if (a_count !== 2'd1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_second_queued: got count=%0d en=%b, want 1 0", a_count, wr_en);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        writes++;
        checks++;
        if (wr_addr !== 5'd7 || wr_data !== 32'h0000_0055) begin
          errors++;
          $display("FAIL zero_write: got addr=%0d data=%h, want 7 00000055", wr_addr, wr_data);
        end
      end
      checks++;
      if (a_count > 2'd1) begin
        errors++;
        $display("FAIL zero_count: got %0d, want <=1", a_count);
      end
    end
    checks++;
    if (writes != 1) begin
      errors++;
      $display("FAIL zero_write_count: got %0d writes, want 1", writes);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (b_count === 2'd2 && a_count !== 2'd0 && wr_en === 1'b1) begin
        hit = 1;
      end else begin
        a_valid = 1'b1; a_addr = 5'(10 + i); a_data = 32'h0A0A_0000 + i;
        b_valid = 1'b1; b_addr = 5'(20 + i); b_data = 32'h0B0B_0000 + i;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_fill: queues never loaded within bound");
    end
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (a_count !== 2'd0 || b_count !== 2'd0 || wr_en !== 1'b0 || a_ready !== 1'b0 ||
        b_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got ac=%0d bc=%0d en=%b ar=%b br=%b, want 0 0 0 0 0",
               a_count, b_count, wr_en, a_ready, b_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || a_count !== 2'd0 || b_count !== 2'd0) begin
        errors++;
        $display("FAIL rstmid_no_write: got en=%b ac=%0d bc=%0d, want 0 0 0",
                 wr_en, a_count, b_count);
      end
    end
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_ready: got ar=%b br=%b, want 1 1", a_ready, b_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 5'd5, 32'hDEAD_BEEF);
    test_single(1'b1, 5'd9, 32'hCAFE_F00D);
    test_contention();
    test_backpressure();
    test_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
